// File: rtl/qei_encoder_gen.sv
// Quadrature encoder emulator: turns a signed edge count and an edge period
// into PHASEA/PHASEB waveforms, tracking cumulative position and edges left.
module qei_encoder_gen #(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             QEG_START_Set,
  input  logic             QEG_ABORT_Set,
  input  logic             QEG_CLEAR_Set,
  input  logic [31:0]      QEG_STEP_Set,
  input  logic [DIV_W-1:0] QEG_DIV_Set,
  output logic             PHASEA,
  output logic             PHASEB,
  output logic             QEG_BUSY_Read,
  output logic             QEG_DONE_Read,
  output logic [31:0]      QEG_POS_Read,
  output logic [31:0]      QEG_REMAIN_Read
);

  // state  | meaning
  // S_IDLE | waiting for a start; phases hold their last value
  // S_RUN  | counting down the edge period and emitting edges
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_dir, w_dir_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [DIV_W-1:0] r_timer, w_timer_nxt;
  logic [31:0]      r_pos, w_pos_nxt;
  logic [31:0]      r_remain, w_remain_nxt;
  logic [1:0]       r_phase, w_phase_nxt;
  logic             r_done, w_done_nxt;
  logic             w_edge;
  logic             w_toggle_a;
  logic [31:0]      w_abs;

  // Two's-complement negate also maps -2^31 onto 0x80000000 as required.
  assign w_abs      = QEG_STEP_Set[31] ? (32'd0 - QEG_STEP_Set) : QEG_STEP_Set;
  // Forward toggles A when the phases match; reverse toggles B when they match.
  assign w_toggle_a = (r_phase[0] == r_phase[1]) ^ r_dir;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_dir    <= 1'b0;
      r_div    <= '0;
      r_timer  <= '0;
      r_pos    <= '0;
      r_remain <= '0;
      r_phase  <= 2'b00;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir    <= w_dir_nxt;
      r_div    <= w_div_nxt;
      r_timer  <= w_timer_nxt;
      r_pos    <= w_pos_nxt;
      r_remain <= w_remain_nxt;
      r_phase  <= w_phase_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dir_nxt    = r_dir;
    w_div_nxt    = r_div;
    w_timer_nxt  = r_timer;
    w_pos_nxt    = r_pos;
    w_remain_nxt = r_remain;
    w_phase_nxt  = r_phase;
    w_done_nxt   = 1'b0;
    w_edge       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (QEG_START_Set && !QEG_ABORT_Set) begin
          w_dir_nxt    = QEG_STEP_Set[31];
          w_remain_nxt = w_abs;
          w_div_nxt    = QEG_DIV_Set;
          w_timer_nxt  = QEG_DIV_Set;
          if (w_abs != 32'd0) w_state_nxt = S_RUN;
          else                w_done_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (QEG_ABORT_Set) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer != '0) begin
          w_timer_nxt = r_timer - DIV_W'(1);
        end else begin
          w_edge       = 1'b1;
          w_remain_nxt = r_remain - 32'd1;
          w_timer_nxt  = r_div;
          if (r_remain == 32'd1) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_edge) begin
      w_phase_nxt = w_toggle_a ? (r_phase ^ 2'b01) : (r_phase ^ 2'b10);
      w_pos_nxt   = r_dir ? (r_pos - 32'd1) : (r_pos + 32'd1);
    end
    // Clear wins over the position step but leaves the phase edge alone.
    if (QEG_CLEAR_Set) w_pos_nxt = 32'd0;
  end

  assign PHASEA          = r_phase[0];
  assign PHASEB          = r_phase[1];
  assign QEG_BUSY_Read   = (r_state == S_RUN);
  assign QEG_DONE_Read   = r_done;
  assign QEG_POS_Read    = r_pos;
  assign QEG_REMAIN_Read = r_remain;

endmodule

// File: tb/tb_qei_encoder_gen.sv
// Scoreboard bench for qei_encoder_gen: directed moves push expected phase
// edges / DONE pulses; a negedge monitor pops and compares each one observed.
module tb_qei_encoder_gen;
  localparam int DIV_W = 16;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             QEG_START_Set = 1'b0;
  logic             QEG_ABORT_Set = 1'b0;
  logic             QEG_CLEAR_Set = 1'b0;
  logic [31:0]      QEG_STEP_Set  = '0;
  logic [DIV_W-1:0] QEG_DIV_Set   = '0;
  logic             PHASEA, PHASEB, QEG_BUSY_Read, QEG_DONE_Read;
  logic [31:0]      QEG_POS_Read, QEG_REMAIN_Read;

  qei_encoder_gen #(.DIV_W(DIV_W)) dut (
    .CLK(CLK), .RST(RST),
    .QEG_START_Set(QEG_START_Set), .QEG_ABORT_Set(QEG_ABORT_Set),
    .QEG_CLEAR_Set(QEG_CLEAR_Set), .QEG_STEP_Set(QEG_STEP_Set),
    .QEG_DIV_Set(QEG_DIV_Set), .PHASEA(PHASEA), .PHASEB(PHASEB),
    .QEG_BUSY_Read(QEG_BUSY_Read), .QEG_DONE_Read(QEG_DONE_Read),
    .QEG_POS_Read(QEG_POS_Read), .QEG_REMAIN_Read(QEG_REMAIN_Read)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [1:0]  ph;
    logic [31:0] pos;
    logic [31:0] rem;
    logic        busy;
  } ev_t;

  ev_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  dec_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(bit d, int c, logic [1:0] ph, logic [31:0] pos,
                      logic [31:0] rem, logic busy);
    ev_t e;
    e.is_done = d; e.cyc = c; e.ph = ph; e.pos = pos; e.rem = rem; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic check_ev(bit is_done, logic [1:0] cur);
    ev_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_%s: got phase %b at cycle %0d, expected no event",
               is_done ? "done" : "edge", cur, cyc);
      return;
    end
    e = sb.pop_front();
    chk(is_done ? "done_kind" : "edge_kind", 32'(is_done), 32'(e.is_done));
    chk("ev_cycle", cyc, e.cyc);
    chk("ev_phase", 32'(cur), 32'(e.ph));
    chk("ev_pos", QEG_POS_Read, e.pos);
    chk("ev_remain", QEG_REMAIN_Read, e.rem);
    chk("ev_busy", 32'(QEG_BUSY_Read), 32'(e.busy));
  endtask

  // Monitor plus a reference decoder counting transitions on the phases.
  initial begin
    logic [1:0] prev, cur;
    prev = 2'b00;
    forever begin
      @(negedge CLK);
      cur = {PHASEB, PHASEA};
      if (RST) begin
        prev = 2'b00;
      end else begin
        if (cur !== prev) begin
          case ({prev, cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: dec_cnt++;
            default: dec_cnt--;
          endcase
          check_ev(1'b0, cur);
        end
        if (QEG_DONE_Read === 1'b1) check_ev(1'b1, cur);
        prev = cur;
      end
    end
  end

  task automatic start_move(logic [31:0] step, logic [DIV_W-1:0] div, output int k);
    QEG_STEP_Set  = step;
    QEG_DIV_Set   = div;
    QEG_START_Set = 1'b1;
    k = cyc + 1;
    @(posedge CLK);
    #1 QEG_START_Set = 1'b0;
  endtask

  task automatic wait_cyc(int t);
    do @(negedge CLK); while (cyc < t);
  endtask

  task automatic pulse_clear();
    QEG_CLEAR_Set = 1'b1;
    @(posedge CLK);
    #1 QEG_CLEAR_Set = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int k;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_phase", 32'({PHASEB, PHASEA}), 32'd0);
    chk("rst_busy", 32'(QEG_BUSY_Read), 32'd0);
    chk("rst_done", 32'(QEG_DONE_Read), 32'd0);
    chk("rst_pos", QEG_POS_Read, 32'd0);
    chk("rst_remain", QEG_REMAIN_Read, 32'd0);

    // Forward 4 edges at full rate
    start_move(32'd4, 16'd0, k);
    push(0, k+1, 2'b01, 32'd1, 32'd3, 1);
    push(0, k+2, 2'b11, 32'd2, 32'd2, 1);
    push(0, k+3, 2'b10, 32'd3, 32'd1, 1);
    push(0, k+4, 2'b00, 32'd4, 32'd0, 0);
    push(1, k+4, 2'b00, 32'd4, 32'd0, 0);
    wait_cyc(k);
    chk("fwd_busy_at_k", 32'(QEG_BUSY_Read), 32'd1);
    wait_cyc(k+6);

    // Reverse 3 edges, D=2, wrapping below zero
    pulse_clear();
    @(negedge CLK);
    chk("clear_idle_pos", QEG_POS_Read, 32'd0);
    start_move(32'hFFFF_FFFD, 16'd2, k);
    push(0, k+3, 2'b10, 32'hFFFF_FFFF, 32'd2, 1);
    push(0, k+6, 2'b11, 32'hFFFF_FFFE, 32'd1, 1);
    push(0, k+9, 2'b01, 32'hFFFF_FFFD, 32'd0, 0);
    push(1, k+9, 2'b01, 32'hFFFF_FFFD, 32'd0, 0);
    wait_cyc(k+11);

    // Abort one clock after the 3rd edge of a 10-edge move, then resume with 1
    pulse_clear();
    @(negedge CLK);
    start_move(32'd10, 16'd1, k);
    push(0, k+2, 2'b11, 32'd1, 32'd9, 1);
    push(0, k+4, 2'b10, 32'd2, 32'd8, 1);
    push(0, k+6, 2'b00, 32'd3, 32'd7, 1);
    wait_cyc(k+6);
    QEG_ABORT_Set = 1'b1;
    @(posedge CLK);
    #1 QEG_ABORT_Set = 1'b0;
    wait_cyc(k+10);
    chk("abort_busy", 32'(QEG_BUSY_Read), 32'd0);
    chk("abort_remain", QEG_REMAIN_Read, 32'd7);
    chk("abort_pos", QEG_POS_Read, 32'd3);
    chk("abort_phase", 32'({PHASEB, PHASEA}), 32'd0);
    start_move(32'd1, 16'd0, k);
    push(0, k+1, 2'b01, 32'd4, 32'd0, 0);
    push(1, k+1, 2'b01, 32'd4, 32'd0, 0);
    wait_cyc(k+3);

    // Start pulsed during RUN with different inputs is ignored
    start_move(32'd3, 16'd1, k);
    push(0, k+2, 2'b11, 32'd5, 32'd2, 1);
    push(0, k+4, 2'b10, 32'd6, 32'd1, 1);
    push(0, k+6, 2'b00, 32'd7, 32'd0, 0);
    push(1, k+6, 2'b00, 32'd7, 32'd0, 0);
    wait_cyc(k+2);
    start_move(32'd5, 16'd0, k);
    k = k - 3;
    wait_cyc(k+9);

    // Zero-length start: single DONE, no edge, never busy
    start_move(32'd0, 16'd5, k);
    push(1, k, 2'b00, 32'd7, 32'd0, 0);
    wait_cyc(k+3);
    chk("zero_busy", 32'(QEG_BUSY_Read), 32'd0);

    // Start with abort in IDLE does nothing
    QEG_ABORT_Set = 1'b1;
    start_move(32'd2, 16'd0, k);
    QEG_ABORT_Set = 1'b0;
    wait_cyc(k+5);
    chk("startabort_busy", 32'(QEG_BUSY_Read), 32'd0);
    chk("startabort_remain", QEG_REMAIN_Read, 32'd0);
    chk("startabort_pos", QEG_POS_Read, 32'd7);

    // Most-negative step latches remain as 0x80000000
    start_move(32'h8000_0000, 16'd100, k);
    wait_cyc(k+1);
    QEG_ABORT_Set = 1'b1;
    @(posedge CLK);
    #1 QEG_ABORT_Set = 1'b0;
    wait_cyc(k+4);
    chk("minneg_remain", QEG_REMAIN_Read, 32'h8000_0000);
    chk("minneg_busy", 32'(QEG_BUSY_Read), 32'd0);

    // Clear collides with the 2nd edge of a 5-edge forward move
    dec_cnt = 0;
    start_move(32'd5, 16'd1, k);
    push(0, k+2,  2'b01, 32'd8, 32'd4, 1);
    push(0, k+4,  2'b11, 32'd0, 32'd3, 1);
    push(0, k+6,  2'b10, 32'd1, 32'd2, 1);
    push(0, k+8,  2'b00, 32'd2, 32'd1, 1);
    push(0, k+10, 2'b01, 32'd3, 32'd0, 0);
    push(1, k+10, 2'b01, 32'd3, 32'd0, 0);
    wait_cyc(k+3);
    pulse_clear();
    wait_cyc(k+12);
    chk("decoder_count", dec_cnt, 32'd5);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
